clk_div_prog: RTL
=================

CLK_DIV_PROG -- requirements
Module: clk_div_prog

Interface
REQ-001 SHALL provide parameter CNT_W, default 8: width of the divisor and period counter.
REQ-002 SHALL provide parameter DIV_RST, default 2: divisor in force after reset (range 2..2^CNT_W-1).
REQ-003 SHALL provide port clk  input  1  sole clock; all state updates on rising edge.
REQ-004 SHALL provide port rst  input  1  synchronous, active-high reset.
REQ-005 SHALL provide port en  input  1  count enable; low freezes all state.
REQ-006 SHALL provide port div_in  input  CNT_W  requested divisor N.
REQ-007 SHALL provide port div_load  input  1  one-cycle strobe capturing div_in as pending divisor.
REQ-008 SHALL provide port div_busy  output  1  high while a pending divisor awaits a period boundary.
REQ-009 SHALL provide port o_clk  output  1  registered divided clock, frequency clk/N.
REQ-010 SHALL provide port o_tick  output  1  one-clk pulse coincident with each o_clk rising transition.

Function
REQ-011 Internal state SHALL be: active divisor N, period counter cnt (0..N-1), pending divisor P, pending flag.
REQ-012 High time H SHALL equal ceil(N/2), low time N-H; even N gives exact 50% duty, odd N gives one extra high cycle.
REQ-013 On an edge with en=1 and cnt=N-1: cnt<=0, o_clk<=1, o_tick<=1.
REQ-014 On an edge with en=1 and cnt<N-1: cnt<=cnt+1, o_clk<=(cnt+1<H), o_tick<=0.
REQ-015 On an edge with en=0: cnt, o_clk, N, and P are held, o_tick<=0, and div_load is still accepted.
REQ-016 On div_load=1, P SHALL take div_in, the pending flag SHALL set, and div_busy SHALL be high from the next cycle.
REQ-017 div_in of 0 or 1 SHALL be clamped to 2 when captured.
REQ-018 A pending divisor SHALL be applied only on the wrap edge of REQ-013: N<=P and the pending flag clears on that edge; the new period starts at that edge, so no runt or stretched pulse occurs.
REQ-019 When div_load coincides with a wrap edge, the divisor already pending (if any) SHALL apply on that edge; the newly loaded value SHALL become pending for the next wrap.
REQ-020 A second div_load while pending SHALL overwrite P; the last value loaded before the wrap wins.
REQ-021 Counter arithmetic SHALL be CNT_W bits unsigned; with N=2^CNT_W-1, cnt reaches 2^CNT_W-2 and wraps with no overflow.
REQ-022 Steady-state o_clk period SHALL be exactly N clk cycles, with o_tick once per period.

Reset
REQ-023 While rst=1 on an edge: N<=DIV_RST, cnt<=DIV_RST-1, P<=DIV_RST, pending flag<=0, o_clk<=0, o_tick<=0, div_busy<=0.
REQ-024 rst SHALL override en and div_load; a pending divisor is discarded.
REQ-025 The first enabled edge after reset SHALL wrap (REQ-013), so o_clk and o_tick rise on that edge.

Configuration
REQ-026 Macro CLK_DIV_DUTY_EN SHALL select programmable duty.
REQ-027 With CLK_DIV_DUTY_EN defined, the block SHALL add input duty_in (CNT_W) captured with div_load, and H SHALL be the captured value clamped to 1..N-1.
REQ-028 With CLK_DIV_DUTY_EN defined, the reset H SHALL be ceil(DIV_RST/2).
REQ-029 Without CLK_DIV_DUTY_EN, the duty_in port SHALL be absent and H SHALL follow REQ-012.

Verification
REQ-030 rst=1 for 2 edges, then en=1, N=DIV_RST=2 -> o_clk toggles every edge and first rises on the first enabled edge; o_tick is high every second edge.
REQ-031 div_load with div_in=5 mid-period of N=2 -> div_busy goes high; o_clk keeps N=2 until the wrap, then shows high 3 and low 2 repeating; div_busy clears on the wrap.
REQ-032 div_in=0 loaded -> behaves as N=2; div_in=255 with CNT_W=8 -> period 255, high 128, low 127, cnt never exceeds 254.
REQ-033 en=0 for 7 cycles mid-high phase at N=6 -> o_clk held high and o_tick=0 throughout; after re-enable the remaining high cycles complete and total period = 6 enabled edges.
REQ-034 div_load 4 then 7 before a wrap, then rst asserted mid-period -> without rst, 7 applies at the wrap; with rst, N returns to 2 and the pending flag clears.
REQ-035 With CLK_DIV_DUTY_EN defined, div_in=8 and duty_in=2 -> high 2, low 6 per period; duty_in=9 clamps to high 7, low 1.

Source files
------------

// File: rtl/clk_div_prog.sv
// Programmable clock divider: o_clk = clk/N with glitch-free divisor changes at period boundaries.
// Optional macro CLK_DIV_DUTY_EN adds duty_in for a programmable high time.
module clk_div_prog #(
    parameter int unsigned CNT_W   = 8,
    parameter int unsigned DIV_RST = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [CNT_W-1:0] div_in,
`ifdef CLK_DIV_DUTY_EN
    input  logic [CNT_W-1:0] duty_in,
`endif
    input  logic             div_load,
    output logic             div_busy,
    output logic             o_clk,
    output logic             o_tick
);

    localparam logic [CNT_W-1:0] DIV_RST_C = CNT_W'(DIV_RST);
    localparam logic [CNT_W-1:0] HI_RST_C  = CNT_W'((DIV_RST + 1) / 2);

    logic [CNT_W-1:0] div_q, div_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] pdiv_q, pdiv_d;
    logic             pend_q, pend_d;
    logic             clk_q, clk_d;
    logic             tick_q, tick_d;
    logic [CNT_W-1:0] hi_c;
    logic             wrap_c;

    // Divisors below 2 cannot form a clock; force them to 2.
    function automatic logic [CNT_W-1:0] clamp_div(input logic [CNT_W-1:0] v);
        return (v < CNT_W'(2)) ? CNT_W'(2) : v;
    endfunction

`ifdef CLK_DIV_DUTY_EN
    logic [CNT_W-1:0] pduty_q, pduty_d;
    logic [CNT_W-1:0] hi_q, hi_d;

    function automatic logic [CNT_W-1:0] clamp_hi(input logic [CNT_W-1:0] duty,
                                                  input logic [CNT_W-1:0] n);
        if (duty == '0)
            return CNT_W'(1);
        else if (duty >= n)
            return n - CNT_W'(1);
        else
            return duty;
    endfunction

    assign hi_c = hi_q;
`else
    assign hi_c = CNT_W'(({1'b0, div_q} + (CNT_W+1)'(1)) >> 1);
`endif

    assign wrap_c = (cnt_q == (div_q - CNT_W'(1)));

    // Next-state: pending divisor swaps in only on the wrap edge.
    always_comb begin
        div_d  = div_q;
        cnt_d  = cnt_q;
        pdiv_d = pdiv_q;
        pend_d = pend_q;
        clk_d  = clk_q;
        tick_d = 1'b0;
`ifdef CLK_DIV_DUTY_EN
        pduty_d = pduty_q;
        hi_d    = hi_q;
`endif
        if (en) begin
            if (wrap_c) begin
                cnt_d  = '0;
                clk_d  = 1'b1;
                tick_d = 1'b1;
                if (pend_q) begin
                    div_d  = pdiv_q;
                    pend_d = 1'b0;
`ifdef CLK_DIV_DUTY_EN
                    hi_d   = clamp_hi(pduty_q, pdiv_q);
`endif
                end
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
                clk_d = ((cnt_q + CNT_W'(1)) < hi_c);
            end
        end
        // A load on the wrap edge queues behind the value just applied.
        if (div_load) begin
            pdiv_d = clamp_div(div_in);
            pend_d = 1'b1;
`ifdef CLK_DIV_DUTY_EN
            pduty_d = duty_in;
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            div_q  <= DIV_RST_C;
            cnt_q  <= DIV_RST_C - CNT_W'(1);
            pdiv_q <= DIV_RST_C;
            pend_q <= 1'b0;
            clk_q  <= 1'b0;
            tick_q <= 1'b0;
`ifdef CLK_DIV_DUTY_EN
            pduty_q <= HI_RST_C;
            hi_q    <= HI_RST_C;
`endif
        end else begin
            div_q  <= div_d;
            cnt_q  <= cnt_d;
            pdiv_q <= pdiv_d;
            pend_q <= pend_d;
            clk_q  <= clk_d;
            tick_q <= tick_d;
`ifdef CLK_DIV_DUTY_EN
            pduty_q <= pduty_d;
            hi_q    <= hi_d;
`endif
        end
    end

`ifndef CLK_DIV_DUTY_EN
    logic unused_c;
    assign unused_c = ^HI_RST_C;
`endif

    assign div_busy = pend_q;
    assign o_clk    = clk_q;
    assign o_tick   = tick_q;

endmodule
